core_seq_ctrl: RTL
==================

Name: core_seq_ctrl

Overview:
- Multi-cycle sequencer for the RV32I datapath. Steps each instruction through fetch, decode, execute, memory and writeback.
- Consumes the instruction decoder's control flags (s, l, w, b), the raw opcode, rd and the branch comparator result.
- Drives the IR latch, decoder enable, PC update, register-file write enable and the imem/dmem request handshakes.
- Sits between the memory interfaces and the decode/ALU/register-file datapath. It is the only source of architectural-state write strobes.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles a memory request may wait for ack before trapping; 0 disables the watchdog.
- CNT_W, 64, width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  holds the sequencer in FETCH before issuing a new request
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch data valid; sampled only while imem_req=1
- ir_we  out  1  latch fetched word into IR
- dec_en  out  1  decoder enable
- opcode  in  7  IR[6:0] of the latched IR
- rd  in  5  destination register index
- dec_s, dec_l, dec_w, dec_b  in  1 each  decoder flags: store, load, reg write, branch/jump
- br_taken  in  1  branch comparator result, valid in EXEC
- dmem_req  out  1  data memory request
- dmem_we  out  1  1 = store, 0 = load; valid with dmem_req
- dmem_ack  in  1  data access complete
- rf_we  out  1  register-file write strobe
- pc_we  out  1  PC update strobe
- pc_sel  out  1  0 = PC+4, 1 = branch/jump target
- retire  out  1  one-cycle pulse per completed instruction
- halted  out  1  sequencer in TRAP
- trap_cause  out  2  0 none, 1 illegal opcode, 2 imem timeout, 3 dmem timeout

Behaviour:
- Reset (async assert, sync release): state=FETCH. All outputs 0. trap_cause=0. Watchdog=0.
- Reset asserted mid-request drops imem_req/dmem_req immediately. No retire occurs for the aborted instruction.
- The first imem_req is issued in the first cycle after release, provided stall=0.
- FETCH:
  - stall=1: imem_req=0, remain in FETCH.
  - Otherwise imem_req=1, held until imem_ack.
  - On ack: ir_we=1 in that cycle, go to DECODE.
  - An ack arriving while req=0 is ignored.
- DECODE (1 cycle): dec_en=1.
  - Opcode not in the legal set {0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011} -> TRAP with cause 1.
  - Otherwise go to EXEC.
- EXEC (1 cycle): dec_en=1.
  - dec_l or dec_s -> MEM.
  - else dec_w -> WB.
  - else retire cycle: pc_we=1, pc_sel = dec_b & br_taken, go to FETCH.
- MEM:
  - dmem_req=1, dmem_we=dec_s, held until dmem_ack.
  - On ack with dec_l -> WB.
  - On ack with a store: retire cycle with pc_sel=0, go to FETCH.
- WB (1 cycle): rf_we = (rd != 0); pc_we=1; pc_sel = dec_b (JAL/JALR always redirect); retire=1; go to FETCH.
- Retire cycle always asserts pc_we=1 and retire=1 together.
- Latency, zero-wait memory: ALU op 4 cycles, branch 3, load 5, store 4.
- Watchdog: counts cycles with a request high and no ack. It clears on ack or on a state change.
  - Count reaching TIMEOUT_CYCLES with no ack -> TRAP, cause 2 (FETCH) or 3 (MEM). The request drops on entry to TRAP.
  - An ack in the same cycle as the limit wins: no trap.
- TRAP: halted=1, all strobes 0, trap_cause held. Exit only through reset. stall is ignored.
- Only one of imem_req and dmem_req is ever high.

Optional Feature:
- CORE_SEQ_PERF_CNT_EN defined: adds outputs cycle_cnt [CNT_W] and instret_cnt [CNT_W].
  - cycle_cnt increments every cycle out of reset and stops in TRAP.
  - instret_cnt increments on retire.
  - Both reset to 0 and wrap modulo 2^CNT_W.
- Undefined: ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Shared defs package gets:
  - seq_state_t enum {FETCH, DECODE, EXEC, MEM, WB, TRAP}
  - trap_cause_t enum {TC_NONE, TC_ILLEGAL, TC_IMEM_TO, TC_DMEM_TO}
  - opcode constants OPC_LUI..OPC_OP (7-bit), shared with the decoder
- Sub-module mem_wdog: parameterised saturating timeout counter (clear, count, expired). It is instantiated once and shared by both memory phases.

Test Plan:
- Reset, then ADDI x1 (opcode 0010011, rd=1) with zero-wait acks -> imem_req high cycle 1; rf_we and pc_we with pc_sel=0 in cycle 4; retire=1 exactly once.
- BEQ (1100011) with br_taken=1, then br_taken=0 -> pc_we in EXEC with pc_sel=1, then pc_sel=0; rf_we never asserted.
- LW (0000011, rd=5) with dmem_ack delayed 3 cycles -> dmem_req=1, dmem_we=0 held 4 cycles; then WB asserts rf_we=1; total 8 cycles.
- SW (0100011), then ADD with rd=0 -> dmem_we=1, no rf_we for the store; ADD asserts retire but rf_we=0.
- Opcode 1111111 -> halted=1 and trap_cause=1 the cycle after DECODE; stall and imem_ack toggling afterward produce no strobes.
- TIMEOUT_CYCLES=4, imem_ack held 0 -> TRAP with cause 2 after 4 request cycles. Then assert rst_n=0 mid-wait in a fresh run -> imem_req drops immediately and the sequencer restarts in FETCH.

Source files
------------

// File: rtl/core_seq_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// core_seq_ctrl_pkg : shared state/trap encodings and RV32I opcode constants
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package core_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } seq_state_t;

  typedef enum logic [1:0] {
    TC_NONE    = 2'd0,
    TC_ILLEGAL = 2'd1,
    TC_IMEM_TO = 2'd2,
    TC_DMEM_TO = 2'd3
  } trap_cause_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  function automatic logic is_legal_opcode(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: is_legal_opcode = 1'b1;
      default:                                 is_legal_opcode = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/core_seq_ctrl_mem_wdog.sv
// ----------------------------------------------------------------------------
// core_seq_ctrl_mem_wdog : saturating memory-ack timeout counter
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module core_seq_ctrl_mem_wdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int c_cnt_w = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  if (LIMIT == 0) begin : g_wdog_off
    logic w_unused;
    assign w_unused = ^{clk, rst_n, clear, count};
    assign expired  = 1'b0;
  end else begin : g_wdog_on
    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (clear) begin
        r_cnt <= '0;
      end else if (count && (r_cnt != c_cnt_w'(LIMIT))) begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
    end

    // Fires in the cycle whose count would reach LIMIT; the caller lets an ack win.
    assign expired = count && (r_cnt == c_cnt_w'(LIMIT - 1));
  end

endmodule

`default_nettype wire

// File: rtl/core_seq_ctrl.sv
// ----------------------------------------------------------------------------
// core_seq_ctrl : multi-cycle RV32I sequencer (fetch/decode/exec/mem/wb/trap)
// Optional macro CORE_SEQ_PERF_CNT_EN adds cycle_cnt / instret_cnt outputs.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module core_seq_ctrl
  import core_seq_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             ir_we,
  output logic             dec_en,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic             dec_s,
  input  logic             dec_l,
  input  logic             dec_w,
  input  logic             dec_b,
  input  logic             br_taken,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             rf_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             retire,
  output logic             halted,
`ifdef CORE_SEQ_PERF_CNT_EN
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
`endif
  output logic [1:0]       trap_cause
);

  if (CNT_W < 1 || TIMEOUT_CYCLES < 0) begin : g_param_chk
    $error("core_seq_ctrl: illegal CNT_W or TIMEOUT_CYCLES");
  end

  seq_state_t  r_state, w_state_nxt;
  trap_cause_t r_trap_cause, w_cause_nxt;
  logic        w_fetch_req;
  logic        w_wdog_clear, w_wdog_count, w_wdog_expired;

  // Gated by rst_n so an in-flight fetch drops the instant reset asserts.
  assign w_fetch_req = rst_n && !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= FETCH;
      r_trap_cause <= TC_NONE;
    end else begin
      r_state      <= w_state_nxt;
      r_trap_cause <= w_cause_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cause_nxt = r_trap_cause;
    case (r_state)
      FETCH: begin
        if (w_fetch_req) begin
          if (imem_ack) begin
            w_state_nxt = DECODE;
          end else if (w_wdog_expired) begin
            w_state_nxt = TRAP;
            w_cause_nxt = TC_IMEM_TO;
          end
        end
      end
      DECODE: begin
        if (is_legal_opcode(opcode)) begin
          w_state_nxt = EXEC;
        end else begin
          w_state_nxt = TRAP;
          w_cause_nxt = TC_ILLEGAL;
        end
      end
      EXEC: begin
        if (dec_l || dec_s)  w_state_nxt = MEM;
        else if (dec_w)      w_state_nxt = WB;
        else                 w_state_nxt = FETCH;
      end
      MEM: begin
        if (dmem_ack) begin
          w_state_nxt = dec_l ? WB : FETCH;
        end else if (w_wdog_expired) begin
          w_state_nxt = TRAP;
          w_cause_nxt = TC_DMEM_TO;
        end
      end
      WB:      w_state_nxt = FETCH;
      TRAP:    w_state_nxt = TRAP;
      default: w_state_nxt = FETCH;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dec_en   = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 1'b0;
    retire   = 1'b0;
    halted   = 1'b0;
    case (r_state)
      FETCH: begin
        imem_req = w_fetch_req;
        ir_we    = w_fetch_req && imem_ack;
      end
      DECODE: dec_en = 1'b1;
      EXEC: begin
        dec_en = 1'b1;
        if (!(dec_l || dec_s || dec_w)) begin
          pc_we  = 1'b1;
          pc_sel = dec_b && br_taken;
          retire = 1'b1;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_s;
        if (dmem_ack && !dec_l) begin
          pc_we  = 1'b1;
          retire = 1'b1;
        end
      end
      WB: begin
        rf_we  = (rd != 5'd0);
        pc_we  = 1'b1;
        pc_sel = dec_b;
        retire = 1'b1;
      end
      TRAP:    halted = 1'b1;
      default: ;
    endcase
  end

  assign trap_cause = r_trap_cause;

  assign w_wdog_count = (imem_req && !imem_ack) || (dmem_req && !dmem_ack);
  assign w_wdog_clear = (w_state_nxt != r_state) || (imem_req && imem_ack) ||
                        (dmem_req && dmem_ack);

  core_seq_ctrl_mem_wdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_mem_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_wdog_clear),
    .count   (w_wdog_count),
    .expired (w_wdog_expired)
  );

`ifdef CORE_SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] r_cycle_cnt, r_instret_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      if (r_state != TRAP) r_cycle_cnt   <= r_cycle_cnt + CNT_W'(1);
      if (retire)          r_instret_cnt <= r_instret_cnt + CNT_W'(1);
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;
`endif

endmodule

`default_nettype wire
